// File: rtl/transmitting.sv
// Serial transmitter: start bit, DATA_BITS data bits LSB first, even parity, stop bit.
// A one-entry holding register lets the next character launch with no idle gap.
module transmitting #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 busy,
    output logic                 data_out,
    output logic                 charSent
);

    localparam int unsigned FRAME_W = DATA_BITS + 3;
    localparam int unsigned SHIFT_W = FRAME_W - 1;
    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]           state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [BIT_W-1:0]     bit_q,      bit_d;
    logic [SHIFT_W-1:0]   shift_q,    shift_d;
    logic [DATA_BITS-1:0] hold_q,     hold_d;
    logic                 hold_vld_q, hold_vld_d;
    logic                 ready_q,    ready_d;
    logic                 busy_q,     busy_d;
    logic                 data_out_q, data_out_d;
    logic                 charsent_q, charsent_d;

    logic                 accept_c;
    logic                 bit_end_c;
    logic [DATA_BITS-1:0] launch_data_c;
    logic [FRAME_W-1:0]   launch_frame_c;

    assign accept_c       = load && ready_q;
    assign bit_end_c      = (cnt_q == CNT_LAST);
    assign launch_data_c  = hold_vld_q ? hold_q : data_in;
    assign launch_frame_c = {1'b1, ^launch_data_c, launch_data_c, 1'b0};

    // State register; reset forces the line idle at once and drops any queued character.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            data_out_q <= 1'b1;
            charsent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            data_out_q <= data_out_d;
            charsent_q <= charsent_d;
        end
    end

    // Next-state and output logic; data_out_d always carries the bit for the coming period.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        busy_d     = busy_q;
        data_out_d = data_out_q;
        charsent_d = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                data_out_d = 1'b1;
                busy_d     = 1'b0;
                cnt_d      = '0;
                bit_d      = '0;
                if (accept_c) begin
                    state_d    = ST_START;
                    shift_d    = launch_frame_c[FRAME_W-1:1];
                    data_out_d = launch_frame_c[0];
                    busy_d     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_d    = ST_DATA;
                    bit_d      = '0;
                    data_out_d = shift_q[0];
                    shift_d    = {1'b0, shift_q[SHIFT_W-1:1]};
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    data_out_d = shift_q[0];
                    shift_d    = {1'b0, shift_q[SHIFT_W-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_PARITY;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d    = ST_STOP;
                    data_out_d = shift_q[0];
                    shift_d    = {1'b0, shift_q[SHIFT_W-1:1]};
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    charsent_d = 1'b1;
                    // Launch straight from holding (or a load landing right now) to avoid a gap.
                    if (hold_vld_q || accept_c) begin
                        state_d    = ST_START;
                        shift_d    = launch_frame_c[FRAME_W-1:1];
                        data_out_d = launch_frame_c[0];
                        hold_vld_d = 1'b0;
                    end else begin
                        state_d    = ST_IDLE;
                        data_out_d = 1'b1;
                        busy_d     = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                data_out_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase

        if (accept_c && (state_q != ST_IDLE) && !((state_q == ST_STOP) && bit_end_c)) begin
            hold_d     = data_in;
            hold_vld_d = 1'b1;
        end

        ready_d = !hold_vld_d;
    end

    assign ready    = ready_q;
    assign busy     = busy_q;
    assign data_out = data_out_q;
    assign charSent = charsent_q;

endmodule

// File: tb/tb_transmitting.sv
// Directed bench for transmitting: cycle-by-cycle line/flag checks against hand-written
// frames, plus a small loopback receiver that reassembles each 10-bit frame.
module tb_transmitting;

    localparam int unsigned CPB   = 16;
    localparam int unsigned FRAME = 10 * CPB;

    logic       clk;
    logic       reset;
    logic [6:0] data_in;
    logic       load;
    logic       ready;
    logic       busy;
    logic       data_out;
    logic       charSent;

    transmitting #(.CLKS_PER_BIT(CPB), .DATA_BITS(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .ready    (ready),
        .busy     (busy),
        .data_out (data_out),
        .charSent (charSent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Loopback receiver: samples mid-bit, first received bit ends up as the MSB.
    logic [9:0] rx_sh;
    logic [9:0] rx_word;
    logic       rx_on;
    int         rx_cnt;
    int         rx_n;
    int         rx_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_on  <= 1'b0;
            rx_cnt <= 0;
            rx_n   <= 0;
            rx_sh  <= '0;
        end else if (!rx_on) begin
            if (data_out == 1'b0) begin
                rx_on  <= 1'b1;
                rx_cnt <= 1;
                rx_n   <= 0;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_sh <= {rx_sh[8:0], data_out};
                rx_n  <= rx_n + 1;
                if (rx_n == 9) begin
                    rx_word <= {rx_sh[8:0], data_out};
                    rx_done <= rx_done + 1;
                    rx_on   <= 1'b0;
                end
            end
        end
    end

    // Scenario description: load edges/data, expected frames (first bit sent = MSB), ready-low window.
    int         ld_cyc [4];
    logic [6:0] ld_dat [4];
    int         n_ld;
    logic [9:0] fr [2];
    int         n_fr;
    int         r_lo;
    int         r_hi;

    task automatic drive_for(input int c);
        load = 1'b0;
        for (int i = 0; i < n_ld; i++) begin
            if (ld_cyc[i] == c) begin
                load    = 1'b1;
                data_in = ld_dat[i];
            end
        end
    endtask

    // Call right after a negedge; cycle c is observed just after rising edge c.
    task automatic run_scen(input string name, input int ncyc);
        int         f;
        int         b;
        logic [9:0] cur;
        logic       e_line;
        logic       e_busy;
        logic       e_cs;
        logic       e_rdy;
        drive_for(0);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            f = c / int'(FRAME);
            b = (c % int'(FRAME)) / int'(CPB);
            if (f < n_fr) begin
                cur    = fr[f];
                e_line = cur[9 - b];
            end else begin
                e_line = 1'b1;
            end
            e_busy = (c < n_fr * int'(FRAME));
            e_cs   = (c > 0) && (c % int'(FRAME) == 0) && (c / int'(FRAME) <= n_fr);
            e_rdy  = !((c >= r_lo) && (c < r_hi));
            check($sformatf("%s line@%0d", name, c), 32'(data_out), 32'(e_line));
            check($sformatf("%s busy@%0d", name, c), 32'(busy), 32'(e_busy));
            check($sformatf("%s charSent@%0d", name, c), 32'(charSent), 32'(e_cs));
            check($sformatf("%s ready@%0d", name, c), 32'(ready), 32'(e_rdy));
            drive_for(c + 1);
        end
        load = 1'b0;
    endtask

    int rx_base;

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        data_in = '0;
        rx_done = 0;
        rx_word = '0;
        repeat (3) @(negedge clk);
        check("rst data_out", 32'(data_out), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst ready", 32'(ready), 32'd1);
        check("rst charSent", 32'(charSent), 32'd0);
        reset = 1'b0;

        // Idle: no load for 200 cycles, line stays high.
        n_ld = 0; n_fr = 0; r_lo = 0; r_hi = 0;
        run_scen("idle", 200);

        // Single frame 7'h4B -> 0,1,1,0,1,0,0,1,0,1 plus loopback.
        rx_base = rx_done;
        n_ld = 1; ld_cyc[0] = 0; ld_dat[0] = 7'h4B;
        n_fr = 1; fr[0] = 10'b0110100101;
        r_lo = 0; r_hi = 0;
        run_scen("single", 180);
        check("loop frames", 32'(rx_done - rx_base), 32'd1);
        check("loop word", 32'(rx_word), 32'(10'b0110100101));

        // Back-to-back: second frame starts exactly at cycle 160.
        rx_base = rx_done;
        n_ld = 2; ld_cyc[1] = 20; ld_dat[1] = 7'h0D;
        n_fr = 2; fr[1] = 10'b0101100011;
        r_lo = 20; r_hi = 160;
        run_scen("b2b", 340);
        check("b2b frames", 32'(rx_done - rx_base), 32'd2);
        check("b2b word", 32'(rx_word), 32'(10'b0101100011));

        // Overflow at 40 and a load on the holding->shifter edge are both dropped.
        rx_base = rx_done;
        n_ld = 4; ld_cyc[2] = 40; ld_dat[2] = 7'h7F; ld_cyc[3] = 160; ld_dat[3] = 7'h7F;
        run_scen("ovf", 360);
        check("ovf frames", 32'(rx_done - rx_base), 32'd2);

        // Reset mid-frame with holding full: line returns high asynchronously.
        n_ld = 2; n_fr = 2; r_lo = 20; r_hi = 160;
        run_scen("prerst", 50);
        @(negedge clk);
        check("prerst line@50", 32'(data_out), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("async data_out", 32'(data_out), 32'd1);
        check("async busy", 32'(busy), 32'd0);
        check("async ready", 32'(ready), 32'd1);
        check("async charSent", 32'(charSent), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check("postrst charSent", 32'(charSent), 32'd0);

        // Fresh 7'h00 frame; the cleared 7'h0D must never appear.
        rx_base = rx_done;
        n_ld = 1; ld_cyc[0] = 0; ld_dat[0] = 7'h00;
        n_fr = 1; fr[0] = 10'b0000000001;
        r_lo = 0; r_hi = 0;
        run_scen("after", 340);
        check("after frames", 32'(rx_done - rx_base), 32'd1);
        check("after word", 32'(rx_word), 32'(10'b0000000001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
